vproc_result_store: RTL and testbench
=====================================

VPROC_RESULT_STORE -- requirements
Module: vproc_result_store

Interface
REQ-001 SHALL have parameter VREG_W, default 128: vector register width in bits, a multiple of RES_W, with VREG_W/RES_W >= 2.
REQ-002 SHALL have parameter RES_W, default 32: result beat width in bits, >= 32.
REQ-003 SHALL use one clock and an asynchronous active-low reset; clk_i  input  1  clock, rising edge.
REQ-004 SHALL have async_rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have res_valid_i  input  1  result beat valid.
REQ-006 SHALL have res_ready_o  output  1  result beat accepted when high together with res_valid_i.
REQ-007 SHALL have res_data_i  input  RES_W  result beat data.
REQ-008 SHALL have res_mask_i  input  RES_W/8  per-byte write mask of the beat.
REQ-009 SHALL have res_vreg_i  input  1  1: vector destination; 0: scalar (xreg) destination.
REQ-010 SHALL have res_base_i  input  5  destination vreg base address, aligned to EMUL.
REQ-011 SHALL have res_emul_i  input  2  cfg_emul encoding (EMUL_1..EMUL_8).
REQ-012 SHALL have res_shift_i  input  1  beat completes the current vreg line.
REQ-013 SHALL have res_last_i  input  1  final beat of the instruction.
REQ-014 SHALL have vreg_wr_en_o  output  1, vreg_wr_addr_o  output  5, vreg_wr_be_o  output  VREG_W/8, vreg_wr_o  output  VREG_W: register-file write port.
REQ-015 SHALL have pend_clear_o  output  32  one-hot clear of pending-write hazard bit.
REQ-016 SHALL have xreg_valid_o  output  1, xreg_o  output  32, xreg_ready_i  input  1: scalar result handshake.

Function
REQ-017 SHALL implement states ACCUM and XWAIT; ACCUM is the reset state.
REQ-018 In ACCUM, res_ready_o SHALL be 1; in XWAIT it SHALL be 0.
REQ-019 An accepted vector beat SHALL place data and mask into slice beat_cnt of the line buffer and then increment beat_cnt.
REQ-020 A line SHALL close on an accepted vector beat with res_shift_i=1, or when beat_cnt = VREG_W/RES_W-1 (implicit shift).
REQ-021 On line close, the merged line SHALL appear on vreg_wr_o/vreg_wr_be_o with vreg_wr_en_o=1 in the next cycle (latency 1) for exactly one cycle.
REQ-022 Bytes of unwritten slices SHALL have be=0.
REQ-023 On line close, beat_cnt and the buffer mask SHALL clear in the same edge, so the next beat is accepted without a stall.
REQ-024 Write address SHALL be res_base_i | {2'b00, mul_cnt}; mul_cnt SHALL increment per line close, modulo the EMUL register count (1/2/4/8).
REQ-025 pend_clear_o SHALL be one-hot at vreg_wr_addr_o in the cycle vreg_wr_en_o=1, else 0.
REQ-026 An accepted res_last_i beat SHALL force line close (if the buffer holds any byte) and clear mul_cnt and beat_cnt.
REQ-027 An accepted last beat with an empty mask SHALL issue no write.
REQ-028 An accepted scalar beat (res_vreg_i=0) SHALL register res_data_i[31:0] into xreg_o, set xreg_valid_o=1 next cycle, and enter XWAIT; it SHALL not touch the line buffer.
REQ-029 In XWAIT, xreg_valid_o=1 and xreg_ready_i=1 SHALL clear xreg_valid_o and return to ACCUM on the next edge.
REQ-030 A line-close write pending when a scalar beat is accepted SHALL still issue in the following cycle.

Reset
REQ-031 On async_rst_ni low, regardless of state: state=ACCUM, beat_cnt=0, mul_cnt=0, buffer mask=0, vreg_wr_en_o=0, pend_clear_o=0, xreg_valid_o=0, xreg_o=0, res_ready_o=1 after release.
REQ-032 A write scheduled for the cycle after reset assertion SHALL be dropped.

Verification
REQ-033 Four full-mask beats 0x11111111..0x44444444, base=8, EMUL_1, last on 4th -> one write: addr 8, data 0x44444444_33333333_22222222_11111111, be all ones, pend_clear_o=1<<8.
REQ-034 Eight beats, EMUL_2, base=4 -> writes at addr 4, then 5; mul_cnt=0 afterwards.
REQ-035 Two beats, shift=1 and last=1 on 2nd -> one write, be=0x00FF.
REQ-036 Scalar beat 0xDEADBEEF, xreg_ready_i held 0 for 3 cycles -> res_ready_o=0 for those cycles, xreg_o=0xDEADBEEF; on ready return to ACCUM.
REQ-037 Reset asserted in the cycle a line closes -> no vreg_wr_en_o pulse; all outputs at reset values.
REQ-038 Back-to-back valid beats across line closes with EMUL_4 -> res_ready_o constantly 1, four writes on consecutive lines.

Source files
------------

// File: rtl/vproc_result_store.sv
// Result store: packs result beats into full vector-register lines and writes them to the
// register file. Scalar results are held on a separate handshake until the consumer takes them.
module vproc_result_store #(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned RES_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,

    input  logic                  res_valid_i,
    output logic                  res_ready_o,
    input  logic [RES_W-1:0]      res_data_i,
    input  logic [RES_W/8-1:0]    res_mask_i,
    input  logic                  res_vreg_i,
    input  logic [4:0]            res_base_i,
    input  logic [1:0]            res_emul_i,
    input  logic                  res_shift_i,
    input  logic                  res_last_i,

    output logic                  vreg_wr_en_o,
    output logic [4:0]            vreg_wr_addr_o,
    output logic [VREG_W/8-1:0]   vreg_wr_be_o,
    output logic [VREG_W-1:0]     vreg_wr_o,

    output logic [31:0]           pend_clear_o,

    output logic                  xreg_valid_o,
    output logic [31:0]           xreg_o,
    input  logic                  xreg_ready_i
);

    localparam int unsigned BEATS   = VREG_W / RES_W;
    localparam int unsigned CNT_W   = $clog2(BEATS);
    localparam int unsigned VBYTES  = VREG_W / 8;
    localparam int unsigned RBYTES  = RES_W / 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        StAccum,
        StXwait
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [2:0]          mul_cnt_q, mul_cnt_d;
    logic [VREG_W-1:0]   buf_data_q, buf_data_d;
    logic [VBYTES-1:0]   buf_mask_q, buf_mask_d;

    logic                wr_en_q, wr_en_d;
    logic [4:0]          wr_addr_q, wr_addr_d;
    logic [VBYTES-1:0]   wr_be_q, wr_be_d;
    logic [VREG_W-1:0]   wr_data_q, wr_data_d;

    logic                xreg_valid_q, xreg_valid_d;
    logic [31:0]         xreg_q, xreg_d;

    logic                accept;
    logic                vec_beat;
    logic                line_close;
    logic [31:0]         beat_idx;
    logic [VREG_W-1:0]   merged_data;
    logic [VBYTES-1:0]   merged_mask;
    logic [2:0]          emul_wrap;

    assign res_ready_o = (state_q == StAccum);
    assign accept      = res_valid_i & res_ready_o;
    assign vec_beat    = accept & res_vreg_i;
    assign beat_idx    = 32'(beat_cnt_q);

    // Buffer contents as they would look with the current beat already written in
    always_comb begin
        merged_data = buf_data_q;
        merged_mask = buf_mask_q;
        merged_data[beat_idx*RES_W +: RES_W]  = res_data_i;
        merged_mask[beat_idx*RBYTES +: RBYTES] = res_mask_i;
    end

    assign line_close = vec_beat & (res_shift_i | res_last_i | (beat_cnt_q == LAST_BEAT));

    always_comb begin
        emul_wrap = 3'b000;
        unique case (res_emul_i)
            2'd0:    emul_wrap = 3'b000;
            2'd1:    emul_wrap = 3'b001;
            2'd2:    emul_wrap = 3'b011;
            2'd3:    emul_wrap = 3'b111;
            default: emul_wrap = 3'b000;
        endcase
    end

    // Line buffer and register-group counters
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        mul_cnt_d  = mul_cnt_q;
        buf_data_d = buf_data_q;
        buf_mask_d = buf_mask_q;
        if (vec_beat) begin
            buf_data_d = merged_data;
            buf_mask_d = merged_mask;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (line_close) begin
            beat_cnt_d = '0;
            buf_mask_d = '0;
            mul_cnt_d  = (mul_cnt_q + 3'd1) & emul_wrap;
        end
        if (vec_beat && res_last_i) begin
            mul_cnt_d = 3'd0;
        end
    end

    // Write port: one-cycle pulse following a line close with any written byte
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_be_d   = wr_be_q;
        wr_data_d = wr_data_q;
        if (line_close) begin
            wr_en_d   = |merged_mask;
            wr_addr_d = res_base_i | {2'b00, mul_cnt_q};
            wr_be_d   = merged_mask;
            wr_data_d = merged_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        xreg_valid_d = xreg_valid_q;
        xreg_d       = xreg_q;
        unique case (state_q)
            StAccum: begin
                if (accept && !res_vreg_i) begin
                    xreg_d       = res_data_i[31:0];
                    xreg_valid_d = 1'b1;
                    state_d      = StXwait;
                end
            end
            StXwait: begin
                if (xreg_valid_q && xreg_ready_i) begin
                    xreg_valid_d = 1'b0;
                    state_d      = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q      <= StAccum;
            beat_cnt_q   <= '0;
            mul_cnt_q    <= 3'd0;
            buf_data_q   <= '0;
            buf_mask_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 5'd0;
            wr_be_q      <= '0;
            wr_data_q    <= '0;
            xreg_valid_q <= 1'b0;
            xreg_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            mul_cnt_q    <= mul_cnt_d;
            buf_data_q   <= buf_data_d;
            buf_mask_q   <= buf_mask_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_be_q      <= wr_be_d;
            wr_data_q    <= wr_data_d;
            xreg_valid_q <= xreg_valid_d;
            xreg_q       <= xreg_d;
        end
    end

    assign vreg_wr_en_o   = wr_en_q;
    assign vreg_wr_addr_o = wr_addr_q;
    assign vreg_wr_be_o   = wr_be_q;
    assign vreg_wr_o      = wr_data_q;
    assign pend_clear_o   = wr_en_q ? (32'd1 << wr_addr_q) : 32'd0;
    assign xreg_valid_o   = xreg_valid_q;
    assign xreg_o         = xreg_q;

endmodule

// File: tb/tb_vproc_result_store.sv
// Scoreboard bench for vproc_result_store: directed beats push expected writes / scalar results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_vproc_result_store;

    localparam int unsigned VREG_W = 128;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned VB     = VREG_W / 8;

    logic                clk_i = 1'b0;
    logic                async_rst_ni = 1'b0;
    logic                res_valid_i = 1'b0;
    logic                res_ready_o;
    logic [RES_W-1:0]    res_data_i = '0;
    logic [RES_W/8-1:0]  res_mask_i = '0;
    logic                res_vreg_i = 1'b0;
    logic [4:0]          res_base_i = '0;
    logic [1:0]          res_emul_i = '0;
    logic                res_shift_i = 1'b0;
    logic                res_last_i = 1'b0;
    logic                vreg_wr_en_o;
    logic [4:0]          vreg_wr_addr_o;
    logic [VB-1:0]       vreg_wr_be_o;
    logic [VREG_W-1:0]   vreg_wr_o;
    logic [31:0]         pend_clear_o;
    logic                xreg_valid_o;
    logic [31:0]         xreg_o;
    logic                xreg_ready_i = 1'b0;

    vproc_result_store #(.VREG_W(VREG_W), .RES_W(RES_W)) dut (
        .clk_i          (clk_i),
        .async_rst_ni   (async_rst_ni),
        .res_valid_i    (res_valid_i),
        .res_ready_o    (res_ready_o),
        .res_data_i     (res_data_i),
        .res_mask_i     (res_mask_i),
        .res_vreg_i     (res_vreg_i),
        .res_base_i     (res_base_i),
        .res_emul_i     (res_emul_i),
        .res_shift_i    (res_shift_i),
        .res_last_i     (res_last_i),
        .vreg_wr_en_o   (vreg_wr_en_o),
        .vreg_wr_addr_o (vreg_wr_addr_o),
        .vreg_wr_be_o   (vreg_wr_be_o),
        .vreg_wr_o      (vreg_wr_o),
        .pend_clear_o   (pend_clear_o),
        .xreg_valid_o   (xreg_valid_o),
        .xreg_o         (xreg_o),
        .xreg_ready_i   (xreg_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]        addr;
        logic [VREG_W-1:0] data;
        logic [VB-1:0]     be;
    } wr_t;

    wr_t          exp_wr[$];
    logic [31:0]  exp_x[$];
    wr_t          mon_e;
    logic [31:0]  mon_x;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [VREG_W-1:0] act,
                         input logic [VREG_W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [VREG_W-1:0] be_bits(input logic [VB-1:0] be);
        logic [VREG_W-1:0] m;
        for (int i = 0; i < int'(VB); i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Monitor
    always @(negedge clk_i) begin
        if (vreg_wr_en_o) begin
            if (exp_wr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d be %0h, no write expected",
                         vreg_wr_addr_o, vreg_wr_be_o);
            end else begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", VREG_W'(vreg_wr_addr_o), VREG_W'(mon_e.addr));
                check("wr_be", VREG_W'(vreg_wr_be_o), VREG_W'(mon_e.be));
                check("wr_data", vreg_wr_o & be_bits(mon_e.be), mon_e.data & be_bits(mon_e.be));
                check("pend_clear", VREG_W'(pend_clear_o), VREG_W'(32'd1 << mon_e.addr));
            end
        end else if (pend_clear_o !== 32'd0) begin
            check("pend_clear_idle", VREG_W'(pend_clear_o), '0);
        end
        if (xreg_valid_o && xreg_ready_i) begin
            if (exp_x.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_xreg: got %0h, none expected", xreg_o);
            end else begin
                mon_x = exp_x.pop_front();
                check("xreg", VREG_W'(xreg_o), VREG_W'(mon_x));
            end
        end
    end

    // Drive one beat and wait (bounded) until it is accepted; returns stall cycles
    task automatic beat(input logic vreg, input logic [31:0] data, input logic [3:0] mask,
                        input logic [4:0] base, input logic [1:0] emul, input logic shift,
                        input logic last, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        res_valid_i = 1'b1;
        res_vreg_i  = vreg;
        res_data_i  = data;
        res_mask_i  = mask;
        res_base_i  = base;
        res_emul_i  = emul;
        res_shift_i = shift;
        res_last_i  = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (res_ready_o) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: ready never seen, expected within 20 cycles");
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        res_valid_i = 1'b0;
        res_shift_i = 1'b0;
        res_last_i  = 1'b0;
    endtask

    task automatic push_wr(input logic [4:0] addr, input logic [VREG_W-1:0] data,
                           input logic [VB-1:0] be);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.be   = be;
        exp_wr.push_back(e);
    endtask

    initial begin
        int st;
        logic [VREG_W-1:0] line;

        repeat (2) @(negedge clk_i);
        check("rst_ready", VREG_W'(res_ready_o), 1);
        check("rst_wr_en", VREG_W'(vreg_wr_en_o), 0);
        check("rst_pend", VREG_W'(pend_clear_o), 0);
        check("rst_xvalid", VREG_W'(xreg_valid_o), 0);
        check("rst_xreg", VREG_W'(xreg_o), 0);
        @(posedge clk_i);
        #1 async_rst_ni = 1'b1;

        // Four full beats, EMUL_1, base 8
        push_wr(5'd8, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
        beat(1, 32'h11111111, 4'hF, 5'd8, 2'd0, 0, 0, st);
        beat(1, 32'h22222222, 4'hF, 5'd8, 2'd0, 0, 0, st);
        beat(1, 32'h33333333, 4'hF, 5'd8, 2'd0, 0, 0, st);
        beat(1, 32'h44444444, 4'hF, 5'd8, 2'd0, 0, 1, st);
        idle();
        repeat (2) @(posedge clk_i);
        #1;

        // Eight beats, EMUL_2, base 4 -> addr 4 then 5
        push_wr(5'd4, 128'h00000004_00000003_00000002_00000001, 16'hFFFF);
        push_wr(5'd5, 128'h00000008_00000007_00000006_00000005, 16'hFFFF);
        for (int i = 1; i <= 8; i++) beat(1, 32'(i), 4'hF, 5'd4, 2'd1, 0, i == 8, st);
        idle();
        @(posedge clk_i);
        #1;

        // Two beats with explicit shift+last; addr 4 again shows mul_cnt cleared
        push_wr(5'd4, 128'h0_66666666_55555555, 16'h00FF);
        beat(1, 32'h55555555, 4'hF, 5'd4, 2'd1, 0, 0, st);
        beat(1, 32'h66666666, 4'hF, 5'd4, 2'd1, 1, 1, st);
        idle();
        @(posedge clk_i);
        #1;

        // Last beat with empty mask and empty buffer: no write
        beat(1, 32'hFFFFFFFF, 4'h0, 5'd0, 2'd0, 0, 1, st);
        idle();
        repeat (2) @(posedge clk_i);
        #1;

        // Line close immediately followed by a scalar beat; write must still issue
        push_wr(5'd12, 128'h0_BBBBBBBB_AAAAAAAA, 16'h00FF);
        beat(1, 32'hAAAAAAAA, 4'hF, 5'd12, 2'd0, 0, 0, st);
        beat(1, 32'hBBBBBBBB, 4'hF, 5'd12, 2'd0, 1, 1, st);
        exp_x.push_back(32'hDEADBEEF);
        beat(0, 32'hDEADBEEF, 4'hF, 5'd0, 2'd0, 0, 1, st);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("xwait_ready", VREG_W'(res_ready_o), 0);
            check("xwait_valid", VREG_W'(xreg_valid_o), 1);
            check("xwait_data", VREG_W'(xreg_o), VREG_W'(32'hDEADBEEF));
            @(posedge clk_i);
            #1;
        end
        xreg_ready_i = 1'b1;
        @(posedge clk_i);
        #1 xreg_ready_i = 1'b0;
        @(negedge clk_i);
        check("xdone_ready", VREG_W'(res_ready_o), 1);
        check("xdone_valid", VREG_W'(xreg_valid_o), 0);
        @(posedge clk_i);
        #1;

        // Reset asserted while a closing beat is presented: write dropped
        beat(1, 32'h77777777, 4'hF, 5'd20, 2'd0, 0, 0, st);
        res_data_i  = 32'h88888888;
        res_shift_i = 1'b1;
        @(negedge clk_i);
        async_rst_ni = 1'b0;
        @(posedge clk_i);
        #1 idle();
        @(negedge clk_i);
        check("rstmid_wr_en", VREG_W'(vreg_wr_en_o), 0);
        check("rstmid_pend", VREG_W'(pend_clear_o), 0);
        check("rstmid_xvalid", VREG_W'(xreg_valid_o), 0);
        check("rstmid_xreg", VREG_W'(xreg_o), 0);
        check("rstmid_ready", VREG_W'(res_ready_o), 1);
        @(posedge clk_i);
        #1 async_rst_ni = 1'b1;
        push_wr(5'd16, 128'h0_12345678, 16'h000F);
        beat(1, 32'h12345678, 4'hF, 5'd16, 2'd0, 0, 1, st);
        idle();
        repeat (2) @(posedge clk_i);
        #1;

        // Back-to-back beats, EMUL_4, base 16 -> four consecutive lines, no stalls
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < 4; j++) line[j*32 +: 32] = 32'hC0DE0000 + 32'(l*4 + j);
            push_wr(5'(16 + l), line, 16'hFFFF);
        end
        for (int i = 0; i < 16; i++) begin
            beat(1, 32'hC0DE0000 + 32'(i), 4'hF, 5'd16, 2'd2, 0, i == 15, st);
            check("b2b_stalls", VREG_W'(st), 0);
        end
        idle();

        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("wr_queue_drained", VREG_W'(exp_wr.size()), 0);
        check("x_queue_drained", VREG_W'(exp_x.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
